// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: drives the IR/red LEDs alternately and reads an ADC0831-style 8-bit serial ADC.
// Optional macro ADC_OVERRANGE_EN adds adc_ovr, which flags full-scale (8'hFF or 8'h00) samples.
module adc_spi_sampler #(
    parameter int SCLK_DIV      = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       adc_sdo,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic       led_ir,
    output logic       led_red,
    output logic [7:0] IR_ADC_Value,
    output logic [7:0] Red_ADC_Value,
    output logic       ir_valid,
    output logic       red_valid,
    output logic       busy
`ifdef ADC_OVERRANGE_EN
    ,
    output logic       adc_ovr
`endif
);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_AT     = TW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(SCLK_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [4:0]    HALF_LAST   = 5'd17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state_r;
    logic [TW-1:0]   timer_r;
    logic [SW-1:0]   settle_r;
    logic [DW-1:0]   div_r;
    logic [4:0]      half_r;
    logic [7:0]      shift_r;
    logic            chan_r;
    logic            tick_s;

`ifdef ADC_OVERRANGE_EN
    function automatic logic is_overrange(input logic [7:0] v);
        return (v == 8'hFF) || (v == 8'h00);
    endfunction
`endif

    // Conversion-start tick on the last count of the sample period
    always_comb begin
        if (enable && (timer_r == TICK_AT)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Free-running sample timer, held at zero while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= TW'(0);
        end else if (!enable || tick_s) begin
            timer_r <= TW'(0);
        end else begin
            timer_r <= timer_r + TW'(1);
        end
    end

    // Sequencer: LED settle, serial frame, result hand-off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            chan_r        <= 1'b0;
            settle_r      <= SW'(0);
            div_r         <= DW'(0);
            half_r        <= 5'd0;
            shift_r       <= 8'h00;
            adc_cs_n      <= 1'b1;
            adc_sclk      <= 1'b0;
            led_ir        <= 1'b0;
            led_red       <= 1'b0;
            IR_ADC_Value  <= 8'h00;
            Red_ADC_Value <= 8'h00;
            ir_valid      <= 1'b0;
            red_valid     <= 1'b0;
            busy          <= 1'b0;
`ifdef ADC_OVERRANGE_EN
            adc_ovr       <= 1'b0;
`endif
        end else begin
            ir_valid  <= 1'b0;
            red_valid <= 1'b0;
`ifdef ADC_OVERRANGE_EN
            adc_ovr   <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    // Ticks outside IDLE fall through here unseen, so they are dropped
                    if (tick_s) begin
                        state_r  <= SETTLE;
                        settle_r <= SW'(0);
                        led_ir   <= ~chan_r;
                        led_red  <= chan_r;
                        busy     <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_r == SETTLE_LAST) begin
                        state_r  <= CONVERT;
                        adc_cs_n <= 1'b0;
                        adc_sclk <= 1'b0;
                        div_r    <= DW'(0);
                        half_r   <= 5'd0;
                        shift_r  <= 8'h00;
                    end else begin
                        settle_r <= settle_r + SW'(1);
                    end
                end
                CONVERT: begin
                    if (div_r == DIV_LAST) begin
                        div_r <= DW'(0);
                        if (half_r == HALF_LAST) begin
                            state_r  <= DONE;
                            adc_cs_n <= 1'b1;
                            adc_sclk <= 1'b0;
                            led_ir   <= 1'b0;
                            led_red  <= 1'b0;
                        end else begin
                            half_r   <= half_r + 5'd1;
                            adc_sclk <= ~adc_sclk;
                            // Sample on the rising sclk edge; the first rise carries the null bit
                            if (!adc_sclk && (half_r != 5'd0)) begin
                                shift_r <= {shift_r[6:0], adc_sdo};
                            end
                        end
                    end else begin
                        div_r <= div_r + DW'(1);
                    end
                end
                DONE: begin
                    if (chan_r) begin
                        Red_ADC_Value <= shift_r;
                        red_valid     <= 1'b1;
                    end else begin
                        IR_ADC_Value  <= shift_r;
                        ir_valid      <= 1'b1;
                    end
`ifdef ADC_OVERRANGE_EN
                    adc_ovr <= is_overrange(shift_r);
`endif
                    chan_r  <= ~chan_r;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b0;
                    led_ir   <= 1'b0;
                    led_red  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule
